// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment codes,
// blink phase encoding and a counter-width helper.
package seg_pkg;

    // Segment codes, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Whole-display blink phase.
    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_e;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-decimal codes go dark.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one BCD digit.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment display driver: shadow registers for the
// digits, a time-division scan over NUM_DIGITS digits, optional
// leading-zero blanking and whole-display blinking. All outputs are
// registered one cycle after the scan index / shadow state they show.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = cnt_width(SCAN_DIV);
    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int FRM_W = cnt_width(BLINK_FRAMES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [CNT_W-1:0]        scan_cnt;
    logic [IDX_W-1:0]        idx;
    logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
    blink_phase_e            phase_q, phase_d;
    logic                    wrap_q;

    logic                    scan_last;
    logic                    wrap;
    logic [3:0]              dig_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic [3:0]              cur_digit;
    logic [6:0]              dec_seg;

    assign scan_last = (scan_cnt == CNT_LAST);
    assign wrap      = scan_last && (idx == IDX_LAST);

    // Shadow registers: capture the presented digits on load, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shadow registers are ordinary flops, so they are cleared by reset like any other state.
            digits_sh <= '0;
            dp_sh     <= '0;
        end else if (load) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            digits_sh <= digits_in;
            dp_sh     <= dp_in;
        end
    end

    // Scan timing: dwell SCAN_DIV cycles per digit, then step to the next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= wrap;
            if (scan_last) begin
                scan_cnt <= '0;
                idx      <= wrap ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Blink state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PHASE_ON;
            frame_cnt_q <= '0;
        end else begin
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Blink next state: count frame wraps, flip phase every BLINK_FRAMES wraps.
    always_comb begin
        phase_d     = phase_q;
        frame_cnt_d = frame_cnt_q;
        if (!blink_en) begin
            phase_d     = PHASE_ON;
            frame_cnt_d = '0;
        end else if (wrap) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Leading-zero mask: a digit is blankable when it and every higher digit are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            dig_arr[i]  = digits_sh[4*i +: 4];
            zero_run    = zero_run && (dig_arr[i] == 4'd0);
            lz_blank[i] = zero_run && (i != 0);
        end
    end

    assign cur_digit = dig_arr[idx];

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Output register: drive the selected digit, or go dark in the blink off phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            an         <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap_q;
            if (phase_q == PHASE_OFF) begin
                seg <= SEG_BLANK;
                dp  <= 1'b0;
                an  <= '0;
            end else begin
                seg <= (blank_lz && lz_blank[idx]) ? SEG_BLANK : dec_seg;
                dp  <= dp_sh[idx];
                an  <= NUM_DIGITS'(1) << idx;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios followed by
// randomized stimulus, compared every cycle against a behavioural model
// that derives the scan position from the elapsed cycle count.
module tb_seg_scan_driver;

    localparam int N     = 3;
    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * SD;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [4*N-1:0]   digits_in = '0;
    logic             load = 1'b0;
    logic [N-1:0]     dp_in = '0;
    logic             blank_lz = 1'b0;
    logic             blink_en = 1'b0;
    logic [6:0]       seg;
    logic             dp;
    logic [N-1:0]     an;
    logic             frame_tick;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release, shadow contents, wraps while blinking.
    int n_edges;
    int sh_dig [N];
    bit sh_dp  [N];
    int wraps;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .load       (load),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] code_of(input int d);
        logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        return tab[d];
    endfunction

    function automatic bit model_off();
        return ((wraps / BF) % 2) == 1;
    endfunction

    function automatic int model_idx();
        return (n_edges / SD) % N;
    endfunction

    task automatic model_reset();
        n_edges = 0;
        wraps   = 0;
        for (int i = 0; i < N; i++) begin
            sh_dig[i] = 0;
            sh_dp[i]  = 1'b0;
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, ".an"},   32'(an),         32'h0);
        check({tag, ".seg"},  32'(seg),        32'h0);
        check({tag, ".dp"},   32'(dp),         32'h0);
        check({tag, ".tick"}, 32'(frame_tick), 32'h0);
    endtask

    // One clock edge: predict outputs, advance the model, compare at the next negedge.
    task automatic tick(input string tag);
        logic [N-1:0] e_an;
        logic [6:0]   e_seg;
        logic         e_dp;
        logic         e_tick;
        int           ix;
        bit           blank;
        ix     = model_idx();
        e_tick = (n_edges > 0) && (n_edges % FRAME == 0);
        if (model_off()) begin
            e_an  = '0;
            e_seg = 7'h00;
            e_dp  = 1'b0;
        end else begin
            blank = blank_lz && (ix != 0);
            for (int j = ix; j < N; j++) if (sh_dig[j] != 0) blank = 1'b0;
            e_an  = N'(1) << ix;
            e_seg = blank ? 7'h00 : code_of(sh_dig[ix]);
            e_dp  = sh_dp[ix];
        end
        @(posedge clk);
        if (load) begin
            for (int i = 0; i < N; i++) begin
                sh_dig[i] = int'(digits_in[4*i +: 4]);
                sh_dp[i]  = dp_in[i];
            end
        end
        n_edges++;
        if (!blink_en) wraps = 0;
        else if (n_edges % FRAME == 0) wraps++;
        @(negedge clk);
        check({tag, ".an"},   32'(an),         32'(e_an));
        check({tag, ".seg"},  32'(seg),        32'(e_seg));
        check({tag, ".dp"},   32'(dp),         32'(e_dp));
        check({tag, ".tick"}, 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic run(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) tick(tag);
    endtask

    task automatic do_load(input string tag, input logic [4*N-1:0] d, input logic [N-1:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        tick(tag);
        load      = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();

        // Power-on reset: every output dark.
        #1 rst_n = 1'b0;
        #11;
        check_dark("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // First edge after release drives digit 0 of an all-zero shadow.
        tick("first");
        check("first.an_is_001", 32'(an), 32'h1);
        check("first.seg_is_3F", 32'(seg), 32'h3F);

        // Basic scan of 359.
        do_load("load359", 12'h359, 3'b010);
        run("scan359", 3 * FRAME);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load("load007", 12'h007, 3'b000);
        run("lz007", FRAME);
        blank_lz = 1'b0;
        run("nolz007", FRAME);
        blank_lz = 1'b1;
        do_load("load000", 12'h000, 3'b100);
        run("lz000", FRAME);

        // Invalid BCD code goes dark without counting as a leading zero.
        do_load("load0A5", 12'h0A5, 3'b001);
        run("bad0A5", FRAME);

        // Blinking, then drop blink_en while dark.
        blink_en = 1'b1;
        run("blink", 5 * FRAME);
        guard = 0;
        while (!model_off() && guard < 4 * FRAME) begin
            tick("blink_wait");
            guard++;
        end
        check("blink.reached_off", 32'(model_off()), 32'h1);
        tick("blink_off");
        blink_en = 1'b0;
        run("unblink", 4);
        check("unblink.an_nonzero", 32'(an != '0), 32'h1);

        // Load landing on an index advance.
        guard = 0;
        while ((n_edges % SD) != SD - 1 && guard < SD) begin
            tick("align");
            guard++;
        end
        do_load("load123", 12'h123, 3'b000);
        run("scan123", 2 * FRAME);

        // Asynchronous reset while digit 2 is driven.
        guard = 0;
        while (an !== 3'b100 && guard < FRAME) begin
            tick("to_dig2");
            guard++;
        end
        check("to_dig2.reached", 32'(an), 32'h4);
        #2 rst_n = 1'b0;
        #1 check_dark("midreset");
        @(negedge clk);
        check_dark("midreset_hold");
        rst_n = 1'b1;
        model_reset();
        tick("after_reset");
        check("after_reset.an", 32'(an), 32'h1);
        check("after_reset.seg", 32'(seg), 32'h3F);
        run("after_reset_scan", FRAME);

        // Randomized traffic with a reset dropped in mid-blink.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                digits_in = 12'($urandom);
                dp_in     = 3'($urandom);
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 63) == 0) blink_en = ~blink_en;
            if (c == 300) begin
                blink_en = 1'b1;
                load     = 1'b0;
                run("rand_preblink", 3 * FRAME + 5);
                #1 rst_n = 1'b0;
                #1 check_dark("rand_reset");
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
            tick("rand");
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, number of multiplexed digits (min 1, max 8).
REQ-002 SHALL have parameter SCAN_DIV, default 4, clock cycles each digit is driven (min 1).
REQ-003 SHALL have parameter BLINK_FRAMES, default 2, full scan frames per blink half-period (min 1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port digits_in  input  4*NUM_DIGITS  BCD digits, digit 0 in bits [3:0], digit 0 least significant.
REQ-007 SHALL have port load  input  1  latch digits_in and dp_in into shadow registers.
REQ-008 SHALL have port dp_in  input  NUM_DIGITS  decimal-point request per digit.
REQ-009 SHALL have port blank_lz  input  1  enable leading-zero blanking.
REQ-010 SHALL have port blink_en  input  1  enable whole-display blinking.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-012 SHALL have port dp  output  1  decimal point of the driven digit, active-high.
REQ-013 SHALL have port an  output  NUM_DIGITS  one-hot digit enable, active-high.
REQ-014 SHALL have port frame_tick  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.

Function
REQ-015 SHALL hold digits and dp in shadow registers; load=1 at a rising edge captures digits_in/dp_in; otherwise the shadow registers hold.
REQ-016 SHALL keep scan counter 0..SCAN_DIV-1; at terminal count, digit index advances by 1, wrapping NUM_DIGITS-1 -> 0; frame = NUM_DIGITS*SCAN_DIV cycles.
REQ-017 SHALL register seg, dp, an every cycle from the current index and shadow state: one-cycle latency from index/shadow change to outputs.
REQ-018 SHALL decode 0-9 as: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, {g..a}); codes 10-15 SHALL give seg=00.
REQ-019 SHALL, with blank_lz=1, blank digit i (seg=00, dp still per shadow) when digit i and all higher digits are 0; digit 0 never blanked.
REQ-020 SHALL keep a blink phase flag toggling after every BLINK_FRAMES frame wraps while blink_en=1; in the off phase an=0, seg=00, dp=0.
REQ-021 SHALL force blink phase to on and clear the frame count within one cycle of blink_en=0.
REQ-022 SHALL assert frame_tick for exactly one cycle, aligned with the output cycle where an changes from bit NUM_DIGITS-1 to bit 0, regardless of blink phase.
REQ-023 SHALL, with load coinciding with an index advance, display the newly loaded value from the next output cycle; the scan sequence is never restarted by load.
REQ-024 SHALL keep an one-hot or all-zero at all times.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force shadow digits=0, shadow dp=0, scan counter=0, index=0, frame count=0, blink phase=on, seg=00, dp=0, an=0, frame_tick=0.
REQ-026 SHALL, on first edge after rst_n release, drive an=...001 with digit 0 of shadow (seg=3F).
REQ-027 SHALL tolerate reset mid-frame or mid-blink with no residual state.

Structure
REQ-028 SHALL place segment code constants (SEG_0..SEG_9, SEG_BLANK=7'h00) in shared package seg_pkg.
REQ-029 SHALL instantiate one combinational sub-module bcd_to_seg (4-bit in, 7-bit out) for decoding; scan, blink and shadow logic live in seg_scan_driver.

Verification
REQ-030 Reset then load digits_in=12'h359, SCAN_DIV=4 -> an cycles 001,010,100 each 4 cycles; seg 6F,6D,4F; frame_tick every 12 cycles.
REQ-031 load 12'h007, blank_lz=1 -> digit2,digit1 seg=00, digit0 seg=07; blank_lz=0 -> digits show 3F,3F,07; load 12'h000, blank_lz=1 -> digit0 shows 3F.
REQ-032 load 12'h0A5 -> digit1 seg=00; digit0 seg=6D.
REQ-033 blink_en=1, BLINK_FRAMES=2 -> outputs active 24 cycles, an=0 next 24 cycles, repeat; drop blink_en during off phase -> an nonzero within 2 cycles.
REQ-034 Assert rst_n=0 mid-frame with digit 2 driven -> an=0, seg=00 immediately; release -> digit 0 first, shadow=0.
REQ-035 load pulse coinciding with index advance, digits_in=12'h123 -> next driven digit shows new value, scan order unbroken.
